dsp_cmd_sequencer: RTL and testbench

//  Command-side driver for the DSP slice: accepts operation commands on a valid/ready stream,

---
 rtl/dsp_cmd_sequencer_if.sv | 24 ++
 rtl/dsp_cmd_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_dsp_cmd_sequencer.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_cmd_sequencer_if.sv
// Command and result streams between a client and dsp_cmd_sequencer.
// The client drives the master side; the sequencer presents the slave side.
interface dsp_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [17:0] cmd_a;
  logic [17:0] cmd_b;
  logic [47:0] cmd_c;
  logic [17:0] cmd_d;
  logic        res_valid;
  logic        res_ready;
  logic [47:0] res_data;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_c, cmd_d, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_c, cmd_d, res_ready,
    output cmd_ready, res_valid, res_data
  );
endinterface

// File: rtl/dsp_cmd_sequencer.sv
// Command-side driver for a DSP slice. Accepted commands are decoded to an
// OPMODE and registered onto the slice ports; a token per issued operation
// walks a DSP_LAT-deep shift register and, on exit, the slice P output is
// pushed into an in-order result FIFO. Issue is throttled by a credit check so
// that every in-flight operation is guaranteed a FIFO slot.
//
// Reset sequencing FSM:
//   state  | meaning
//   S_HOLD | slice held in reset (dsp_rst=1, dsp_ce=0), counting release edges
//   S_RUN  | slice running (dsp_rst=0, dsp_ce=1), commands may be accepted
module dsp_cmd_sequencer #(
  parameter int DSP_LAT    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  dsp_cmd_sequencer_if.slave bus,
  output logic               err_illegal,
  output logic [17:0]        dsp_a,
  output logic [17:0]        dsp_b,
  output logic [17:0]        dsp_d,
  output logic [47:0]        dsp_c,
  output logic [7:0]         dsp_opmode,
  output logic               dsp_ce,
  output logic               dsp_rst,
  input  logic [47:0]        dsp_p
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W = $clog2(DSP_LAT + FIFO_DEPTH + 1);
  // Number of clock edges the slice stays in reset after rst_n rises.
  localparam logic [1:0] RST_EDGES = 2'd2;

  typedef enum logic {
    S_HOLD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  rst_cnt_q, rst_cnt_d;
  logic        dsp_rst_q, dsp_rst_d;
  logic        dsp_ce_q, dsp_ce_d;

  logic [17:0] a_q, a_d;
  logic [17:0] b_q, b_d;
  logic [17:0] d_q, d_d;
  logic [47:0] c_q, c_d;
  logic [7:0]  opmode_q, opmode_d;
  logic        err_q, err_d;
  logic [DSP_LAT-1:0] tok_q, tok_d;

  logic [47:0]      mem_q [FIFO_DEPTH];
  logic [47:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

  logic             op_legal;
  logic [7:0]       opmode_dec;
  logic [CRD_W-1:0] inflight;
  logic [CRD_W-1:0] credits_used;
  logic             cmd_ready_int;
  logic             accept;
  logic             issue;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reset sequencer: next state and slice RST/CE levels.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    dsp_rst_d = 1'b1;
    dsp_ce_d  = 1'b0;
    case (state_q)
      S_HOLD: begin
        rst_cnt_d = rst_cnt_q - 2'd1;
        if (rst_cnt_q == 2'd1) begin
          state_d   = S_RUN;
          dsp_rst_d = 1'b0;
          dsp_ce_d  = 1'b1;
        end
      end
      S_RUN: begin
        dsp_rst_d = 1'b0;
        dsp_ce_d  = 1'b1;
      end
      default: state_d = S_HOLD;
    endcase
  end

  // Reset sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_HOLD;
      rst_cnt_q <= RST_EDGES;
      dsp_rst_q <= 1'b1;
      dsp_ce_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      dsp_rst_q <= dsp_rst_d;
      dsp_ce_q  <= dsp_ce_d;
    end
  end

  // Opcode to OPMODE decode; codes 6 and 7 are illegal.
  always_comb begin
    op_legal   = 1'b1;
    opmode_dec = 8'h00;
    case (bus.cmd_op)
      3'd0:    opmode_dec = 8'h01;
      3'd1:    opmode_dec = 8'h09;
      3'd2:    opmode_dec = 8'h11;
      3'd3:    opmode_dec = 8'h51;
      3'd4:    opmode_dec = 8'h0D;
      3'd5:    opmode_dec = 8'h8D;
      default: op_legal   = 1'b0;
    endcase
  end

  // Credits: operations still in the slice plus results waiting in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < DSP_LAT; i++) begin
      inflight = inflight + CRD_W'(tok_q[i]);
    end
    credits_used = inflight + CRD_W'(fifo_cnt_q);
  end

  assign cmd_ready_int = !dsp_rst_q && (credits_used < CRD_W'(FIFO_DEPTH));
  assign accept        = bus.cmd_valid & cmd_ready_int;
  assign issue         = accept & op_legal;

  // Issue path: load slice ports on a legal accept, otherwise hold them so
  // the slice keeps seeing stable operands; illegal accepts only flag.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    opmode_d = opmode_q;
    if (issue) begin
      a_d      = bus.cmd_a;
      b_d      = bus.cmd_b;
      c_d      = bus.cmd_c;
      d_d      = bus.cmd_d;
      opmode_d = opmode_dec;
    end
    err_d = err_q | (accept & ~op_legal);
    tok_d = {tok_q[DSP_LAT-2:0], issue};
  end

  // Slice port, error flag and token registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      opmode_q <= '0;
      err_q    <= 1'b0;
      tok_q    <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      opmode_q <= opmode_d;
      err_q    <= err_d;
      tok_q    <= tok_d;
    end
  end

  assign push = tok_q[DSP_LAT-1];
  assign pop  = (fifo_cnt_q != '0) & bus.res_ready;

  // Result FIFO: capture P as a token exits, pop on the result handshake.
  // The credit check guarantees a free slot for every push.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = dsp_p;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Result FIFO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_int;
  assign bus.res_valid = (fifo_cnt_q != '0);
  assign bus.res_data  = mem_q[rd_ptr_q];
  assign err_illegal   = err_q;
  assign dsp_a         = a_q;
  assign dsp_b         = b_q;
  assign dsp_c         = c_q;
  assign dsp_d         = d_q;
  assign dsp_opmode    = opmode_q;
  assign dsp_ce        = dsp_ce_q;
  assign dsp_rst       = dsp_rst_q;

endmodule

// File: tb/tb_dsp_cmd_sequencer.sv
// Bench for dsp_cmd_sequencer. A behavioural DSP slice drives dsp_p: the
// sequencer's own port register acts as the slice input stage, followed by an
// M stage and a P stage, so P for an operation issued at edge t is presented
// before edge t+3. Expected results come from a per-opcode arithmetic model.
module tb_dsp_cmd_sequencer;

  logic        clk;
  logic        rst_n;
  logic        err_illegal;
  logic [17:0] dsp_a, dsp_b, dsp_d;
  logic [47:0] dsp_c;
  logic [7:0]  dsp_opmode;
  logic        dsp_ce, dsp_rst;
  logic [47:0] dsp_p;

  dsp_cmd_sequencer_if bus ();

  dsp_cmd_sequencer #(.DSP_LAT(3), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .err_illegal(err_illegal),
    .dsp_a      (dsp_a),
    .dsp_b      (dsp_b),
    .dsp_d      (dsp_d),
    .dsp_c      (dsp_c),
    .dsp_opmode (dsp_opmode),
    .dsp_ce     (dsp_ce),
    .dsp_rst    (dsp_rst),
    .dsp_p      (dsp_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural slice ----------------
  logic [47:0] m_q, sc_q, p_q;
  logic [7:0]  mode_q;

  function automatic logic [47:0] slice_mult(input logic [7:0] om, input logic [17:0] a,
                                             input logic [17:0] b, input logic [17:0] d);
    longint la, lb, ld, r;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    ld = longint'($signed(d));
    case (om)
      8'h11:   r = (ld + lb) * la;
      8'h51:   r = (ld - lb) * la;
      default: r = la * lb;
    endcase
    return r[47:0];
  endfunction

  always @(posedge clk) begin
    if (dsp_rst) begin
      m_q <= '0; sc_q <= '0; p_q <= '0; mode_q <= '0;
    end else if (dsp_ce) begin
      m_q    <= slice_mult(dsp_opmode, dsp_a, dsp_b, dsp_d);
      sc_q   <= dsp_c;
      mode_q <= dsp_opmode;
      case (mode_q)
        8'h01, 8'h11, 8'h51: p_q <= m_q;
        8'h09:               p_q <= p_q + m_q;
        8'h0D:               p_q <= sc_q + m_q;
        8'h8D:               p_q <= sc_q - m_q;
        default:             p_q <= p_q;
      endcase
    end
  end
  assign dsp_p = p_q;

  // ---------------- reference model and scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_results = 0;
  logic [47:0] exp_q[$];
  longint      acc = 0;
  logic        exp_err = 1'b0;
  bit          rand_ready = 1'b0;

  task automatic model_accept(input logic [2:0] op, input logic [17:0] a, input logic [17:0] b,
                              input logic [47:0] c, input logic [17:0] d);
    longint la, lb, lc, ld;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    lc = longint'($signed(c));
    ld = longint'($signed(d));
    case (op)
      3'd0: acc = la * lb;
      3'd1: acc = acc + la * lb;
      3'd2: acc = (ld + lb) * la;
      3'd3: acc = (ld - lb) * la;
      3'd4: acc = lc + la * lb;
      3'd5: acc = lc - la * lb;
      default: begin
        exp_err = 1'b1;
        return;
      end
    endcase
    exp_q.push_back(acc[47:0]);
  endtask

  // Result monitor: in-order data check and head stability under backpressure.
  logic        prev_stall = 1'b0;
  logic [47:0] prev_data;
  always @(negedge clk) begin
    logic [47:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== prev_data) begin
          n_fail++;
          $display("FAIL res_hold: valid=%b data=%h, required valid=1 data=%h",
                   bus.res_valid, bus.res_data, prev_data);
        end
      end
      if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
        n_checks++;
        n_results++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL res_unexpected: got %h, no result expected", bus.res_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.res_data !== e) begin
            n_fail++;
            $display("FAIL res_data: got %h, required %h", bus.res_data, e);
          end
        end
      end
      prev_stall = (bus.res_valid === 1'b1) && (bus.res_ready !== 1'b1);
      prev_data  = bus.res_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_ready) bus.res_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [2:0] op, input logic [17:0] a, input logic [17:0] b,
                      input logic [47:0] c, input logic [17:0] d);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_c = c; bus.cmd_d = d;
    while (bus.cmd_ready !== 1'b1 && n < 200) begin
      cyc();
      n++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, n);
      bus.cmd_valid = 1'b0;
      return;
    end
    cyc();
    model_accept(op, a, b, c, d);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    bus.res_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.res_valid === 1'b1) && n < 100) begin
      cyc();
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0 || bus.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_%s: %0d results outstanding, res_valid=%b, required 0 and 0",
               tag, exp_q.size(), bus.res_valid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.cmd_c = '0; bus.cmd_d = '0; bus.res_ready = 1'b0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (dsp_rst !== 1'b1 || dsp_ce !== 1'b0 || bus.cmd_ready !== 1'b0 ||
        bus.res_valid !== 1'b0 || err_illegal !== 1'b0 || dsp_opmode !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: rst=%b ce=%b rdy=%b rv=%b err=%b om=%h, required 1 0 0 0 0 00",
               dsp_rst, dsp_ce, bus.cmd_ready, bus.res_valid, err_illegal, dsp_opmode);
    end
    rst_n = 1'b1;
    cyc();
    n_checks++;
    if (dsp_rst !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_edge1: dsp_rst=%b cmd_ready=%b, required 1 0", dsp_rst, bus.cmd_ready);
    end
    cyc();
    n_checks++;
    if (dsp_rst !== 1'b0 || dsp_ce !== 1'b1 || bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_edge2: dsp_rst=%b dsp_ce=%b cmd_ready=%b, required 0 1 1",
               dsp_rst, dsp_ce, bus.cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    bus.res_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'd0; bus.cmd_a = 18'd3; bus.cmd_b = 18'd5; bus.cmd_c = '0; bus.cmd_d = '0;
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: cmd_ready=%b, required 1", bus.cmd_ready);
    end
    cyc();
    model_accept(3'd0, 18'd3, 18'd5, 48'd0, 18'd0);
    n_checks++;
    if (dsp_opmode !== 8'h01 || dsp_a !== 18'd3 || dsp_b !== 18'd5) begin
      n_fail++;
      $display("FAIL b2b_issue_mul: om=%h a=%0d b=%0d, required 01 3 5", dsp_opmode, dsp_a, dsp_b);
    end
    bus.cmd_op = 3'd3; bus.cmd_a = 18'd7; bus.cmd_b = 18'd4; bus.cmd_d = 18'd10;
    cyc();
    model_accept(3'd3, 18'd7, 18'd4, 48'd0, 18'd10);
    bus.cmd_valid = 1'b0;
    n_checks++;
    if (dsp_opmode !== 8'h51 || dsp_a !== 18'd7 || dsp_d !== 18'd10) begin
      n_fail++;
      $display("FAIL b2b_issue_presub: om=%h a=%0d d=%0d, required 51 7 10", dsp_opmode, dsp_a, dsp_d);
    end
    cyc();
    n_checks++;
    if (bus.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_early: res_valid=%b two edges after issue, required 0", bus.res_valid);
    end
    cyc();
    n_checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 48'd15) begin
      n_fail++;
      $display("FAIL b2b_lat3: valid=%b data=%0d, required 1 15", bus.res_valid, bus.res_data);
    end
    cyc();
    n_checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 48'd42) begin
      n_fail++;
      $display("FAIL b2b_lat4: valid=%b data=%0d, required 1 42", bus.res_valid, bus.res_data);
    end
    cyc();
    n_checks++;
    if (bus.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_empty: res_valid=%b, required 0", bus.res_valid);
    end
    drain("b2b");
  endtask

  task automatic test_mac_chain();
    int r0 = n_results;
    bus.res_ready = 1'b1;
    send(3'd0, 18'd2, 18'd3, 48'd0, 18'd0);
    send(3'd1, 18'd4, 18'd5, 48'd0, 18'd0);
    send(3'd1, 18'd1, 18'd1, 48'd0, 18'd0);
    drain("mac");
    n_checks++;
    if (n_results - r0 != 3) begin
      n_fail++;
      $display("FAIL mac_count: got %0d results, required 3", n_results - r0);
    end
  endtask

  task automatic test_backpressure();
    int acc_n = 0;
    int r0 = n_results;
    bit ok;
    bus.res_ready = 1'b0;
    for (int cy = 0; cy < 12; cy++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op = 3'd0; bus.cmd_a = 18'(acc_n + 1); bus.cmd_b = 18'(acc_n + 10);
      bus.cmd_c = '0; bus.cmd_d = '0;
      ok = (bus.cmd_ready === 1'b1);
      cyc();
      if (ok) begin
        model_accept(3'd0, 18'(acc_n + 1), 18'(acc_n + 10), 48'd0, 18'd0);
        acc_n++;
      end
    end
    bus.cmd_valid = 1'b0;
    n_checks++;
    if (acc_n != 4 || bus.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_credit: accepted=%0d cmd_ready=%b, required 4 0", acc_n, bus.cmd_ready);
    end
    n_checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 48'd10) begin
      n_fail++;
      $display("FAIL bp_head: valid=%b data=%0d, required 1 10", bus.res_valid, bus.res_data);
    end
    bus.res_ready = 1'b1;
    while (acc_n < 6) begin
      send(3'd0, 18'(acc_n + 1), 18'(acc_n + 10), 48'd0, 18'd0);
      acc_n++;
    end
    drain("bp");
    n_checks++;
    if (n_results - r0 != 6) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results, required 6", n_results - r0);
    end
  endtask

  task automatic test_illegal();
    int r0 = n_results;
    bus.res_ready = 1'b1;
    send(3'd7, 18'd9, 18'd9, 48'd9, 18'd9);
    repeat (6) cyc();
    n_checks++;
    if (err_illegal !== 1'b1 || bus.res_valid !== 1'b0 || n_results != r0) begin
      n_fail++;
      $display("FAIL illegal_flag: err=%b res_valid=%b results=%0d, required 1 0 0",
               err_illegal, bus.res_valid, n_results - r0);
    end
    send(3'd4, 18'd2, 18'd3, 48'd100, 18'd0);
    drain("illegal");
    n_checks++;
    if (err_illegal !== 1'b1 || n_results - r0 != 1) begin
      n_fail++;
      $display("FAIL illegal_after: err=%b results=%0d, required 1 1", err_illegal, n_results - r0);
    end
  endtask

  task automatic test_random();
    logic [2:0] ops [7];
    int r0 = n_results;
    int sent = 0;
    ops[0] = 3'd0; ops[1] = 3'd2; ops[2] = 3'd3; ops[3] = 3'd4;
    ops[4] = 3'd5; ops[5] = 3'd6; ops[6] = 3'd7;
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      op = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) cyc();
      send(op, 18'($urandom_range(0, 32767)), 18'($urandom_range(0, 32767)),
           {8'd0, 32'($urandom)}, 18'($urandom_range(0, 32767)));
      if (op <= 3'd5) sent++;
    end
    rand_ready = 1'b0;
    drain("random");
    n_checks++;
    if (n_results - r0 != sent || err_illegal !== exp_err) begin
      n_fail++;
      $display("FAIL random_totals: results=%0d err=%b, required %0d %b",
               n_results - r0, err_illegal, sent, exp_err);
    end
  endtask

  task automatic test_reset_inflight();
    int n = 0;
    bit stale = 1'b0;
    bus.res_ready = 1'b0;
    send(3'd0, 18'd9, 18'd9, 48'd0, 18'd0);
    while (bus.res_valid !== 1'b1 && n < 10) begin
      cyc();
      n++;
    end
    send(3'd0, 18'd2, 18'd2, 48'd0, 18'd0);
    send(3'd0, 18'd3, 18'd3, 48'd0, 18'd0);
    n_checks++;
    if (bus.res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_setup: res_valid=%b before reset, required 1", bus.res_valid);
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_err = 1'b0;
    n_checks++;
    if (bus.res_valid !== 1'b0 || dsp_rst !== 1'b1 || bus.cmd_ready !== 1'b0 || err_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: rv=%b rst=%b rdy=%b err=%b, required 0 1 0 0",
               bus.res_valid, dsp_rst, bus.cmd_ready, err_illegal);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (bus.res_valid !== 1'b0) stale = 1'b1;
    end
    n_checks++;
    if (stale || n_results == 0) begin
      n_fail++;
      $display("FAIL rst_stale: stale result seen=%b, required 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mac_chain();
    test_backpressure();
    test_illegal();
    test_random();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
